// File: rtl/dcache_tag_array_nway.sv
// N-way set-associative tag store with per-set round-robin victim pointer.
// Registered one-cycle lookup; INIT and FLUSH sweep one set per cycle.
module dcache_tag_array_nway #(
  parameter int NUM_WAYS  = 4,
  parameter int NUM_SETS  = 128,
  parameter int TAG_WIDTH = 20,
  localparam int SET_W = $clog2(NUM_SETS),
  localparam int WAY_W = $clog2(NUM_WAYS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req,
  input  logic [1:0]           op,
  input  logic [SET_W-1:0]     addr,
  input  logic [TAG_WIDTH-1:0] tag,
  input  logic [WAY_W-1:0]     way_sel,
  input  logic                 wdirty,
  input  logic                 flush_req,
  output logic                 ready,
  output logic                 rvalid,
  output logic                 hit,
  output logic [NUM_WAYS-1:0]  hit_way,
  output logic                 rdirty,
  output logic [WAY_W-1:0]     victim_way,
  output logic                 victim_valid,
  output logic                 victim_dirty,
  output logic [TAG_WIDTH-1:0] victim_tag,
  output logic                 flush_done
);

  typedef enum logic [1:0] {
    S_INIT,
    S_READY,
    S_FLUSH
  } state_e;

  localparam logic [1:0] OP_LOOKUP = 2'b00;
  localparam logic [1:0] OP_FILL   = 2'b01;
  localparam logic [1:0] OP_SETD   = 2'b10;
  localparam logic [1:0] OP_INV    = 2'b11;

  logic [TAG_WIDTH-1:0] tag_mem   [NUM_SETS][NUM_WAYS];
  logic [NUM_WAYS-1:0]  valid_mem [NUM_SETS];
  logic [NUM_WAYS-1:0]  dirty_mem [NUM_SETS];
  logic [WAY_W-1:0]     rr_mem    [NUM_SETS];

  state_e               state_q, state_d;
  logic [SET_W-1:0]     cnt_q, cnt_d;
  logic                 ready_q, ready_d;
  logic                 rvalid_q, rvalid_d;
  logic                 hit_q, hit_d;
  logic [NUM_WAYS-1:0]  hit_way_q, hit_way_d;
  logic                 rdirty_q, rdirty_d;
  logic [WAY_W-1:0]     vway_q, vway_d;
  logic                 vvalid_q, vvalid_d;
  logic                 vdirty_q, vdirty_d;
  logic [TAG_WIDTH-1:0] vtag_q, vtag_d;
  logic                 fdone_q, fdone_d;

  logic                 accept;
  logic                 sweep;
  logic [NUM_WAYS-1:0]  cur_valid, cur_dirty;
  logic [NUM_WAYS-1:0]  new_valid, new_dirty;
  logic [NUM_WAYS-1:0]  fill_oh, sel_oh, match, hit_oh;
  logic [WAY_W-1:0]     cur_rr;

  logic                 mem_we;
  logic [SET_W-1:0]     mem_set;
  logic [NUM_WAYS-1:0]  mem_valid, mem_dirty;
  logic [WAY_W-1:0]     mem_rr;
  logic                 tag_we;

  assign accept = (state_q == S_READY) && ready_q && req && !flush_req;
  assign sweep  = (state_q != S_READY);

  // Post-write view of the addressed set; results are taken from this.
  always_comb begin
    cur_valid = valid_mem[addr];
    cur_dirty = dirty_mem[addr];
    cur_rr    = rr_mem[addr];
    fill_oh   = '0;
    fill_oh[cur_rr] = 1'b1;
    sel_oh    = '0;
    sel_oh[way_sel] = 1'b1;
    new_valid = cur_valid;
    new_dirty = cur_dirty;
    unique case (op)
      OP_LOOKUP: ;
      OP_FILL: begin
        new_valid = cur_valid | fill_oh;
        new_dirty = wdirty ? (cur_dirty | fill_oh)
                           : (cur_dirty & ~fill_oh);
      end
      OP_SETD: new_dirty = cur_dirty | (sel_oh & cur_valid);
      OP_INV: begin
        new_valid = cur_valid & ~sel_oh;
        new_dirty = cur_dirty & ~sel_oh;
      end
    endcase
    match = '0;
    for (int w = 0; w < NUM_WAYS; w++)
      match[w] = new_valid[w] && (tag_mem[addr][w] == tag);
    hit_oh = match & (~match + NUM_WAYS'(1));
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ready_d  = ready_q;
    rvalid_d = 1'b0;
    fdone_d  = 1'b0;
    hit_d    = hit_q;
    hit_way_d = hit_way_q;
    rdirty_d = rdirty_q;
    vway_d   = vway_q;
    vvalid_d = vvalid_q;
    vdirty_d = vdirty_q;
    vtag_d   = vtag_q;
    unique case (state_q)
      S_INIT, S_FLUSH: begin
        cnt_d = cnt_q + SET_W'(1);
        if (cnt_q == SET_W'(NUM_SETS - 1)) begin
          state_d = S_READY;
          ready_d = 1'b1;
          fdone_d = (state_q == S_FLUSH);
          cnt_d   = '0;
        end
      end
      S_READY: begin
        if (flush_req) begin
          state_d = S_FLUSH;
          ready_d = 1'b0;
          cnt_d   = '0;
        end else if (accept) begin
          rvalid_d = 1'b1;
          vway_d   = cur_rr;
          vtag_d   = tag_mem[addr][cur_rr];
          if (op == OP_FILL) begin
            hit_d     = 1'b1;
            hit_way_d = fill_oh;
            rdirty_d  = wdirty;
            vvalid_d  = cur_valid[cur_rr];
            vdirty_d  = cur_dirty[cur_rr];
          end else begin
            hit_d     = |match;
            hit_way_d = hit_oh;
            rdirty_d  = |(hit_oh & new_dirty);
            vvalid_d  = new_valid[cur_rr];
            vdirty_d  = new_dirty[cur_rr];
          end
        end
      end
      default: begin
        state_d = S_INIT;
        cnt_d   = '0;
        ready_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    mem_we    = sweep || accept;
    mem_set   = sweep ? cnt_q : addr;
    mem_valid = sweep ? '0 : new_valid;
    mem_dirty = sweep ? '0 : new_dirty;
    mem_rr    = '0;
    if (!sweep)
      mem_rr = (op == OP_FILL) ? cur_rr + WAY_W'(1) : cur_rr;
    tag_we    = accept && (op == OP_FILL);
  end

  // Storage has no reset; the INIT sweep clears it.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      valid_mem[mem_set] <= mem_valid;
      dirty_mem[mem_set] <= mem_dirty;
      rr_mem[mem_set]    <= mem_rr;
    end
    if (tag_we)
      tag_mem[addr][cur_rr] <= tag;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_INIT;
      cnt_q     <= '0;
      ready_q   <= 1'b0;
      rvalid_q  <= 1'b0;
      hit_q     <= 1'b0;
      hit_way_q <= '0;
      rdirty_q  <= 1'b0;
      vway_q    <= '0;
      vvalid_q  <= 1'b0;
      vdirty_q  <= 1'b0;
      vtag_q    <= '0;
      fdone_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ready_q   <= ready_d;
      rvalid_q  <= rvalid_d;
      hit_q     <= hit_d;
      hit_way_q <= hit_way_d;
      rdirty_q  <= rdirty_d;
      vway_q    <= vway_d;
      vvalid_q  <= vvalid_d;
      vdirty_q  <= vdirty_d;
      vtag_q    <= vtag_d;
      fdone_q   <= fdone_d;
    end
  end

  assign ready        = ready_q;
  assign rvalid       = rvalid_q;
  assign hit          = hit_q;
  assign hit_way      = hit_way_q;
  assign rdirty       = rdirty_q;
  assign victim_way   = vway_q;
  assign victim_valid = vvalid_q;
  assign victim_dirty = vdirty_q;
  assign victim_tag   = vtag_q;
  assign flush_done   = fdone_q;

endmodule

// File: tb/tb_dcache_tag_array_nway.sv
// Randomized scoreboard bench for dcache_tag_array_nway against
// a set/way array model of the tag store.
module tb_dcache_tag_array_nway;

  localparam int NW = 4;
  localparam int NS = 128;
  localparam int TW = 20;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req = 1'b0;
  logic [1:0]    op = '0;
  logic [6:0]    addr = '0;
  logic [TW-1:0] tag = '0;
  logic [1:0]    way_sel = '0;
  logic          wdirty = 1'b0;
  logic          flush_req = 1'b0;
  logic          ready, rvalid, hit, rdirty;
  logic [NW-1:0] hit_way;
  logic [1:0]    victim_way;
  logic          victim_valid, victim_dirty, flush_done;
  logic [TW-1:0] victim_tag;

  dcache_tag_array_nway dut (
    .clk(clk), .rst_n(rst_n), .req(req), .op(op),
    .addr(addr), .tag(tag), .way_sel(way_sel),
    .wdirty(wdirty), .flush_req(flush_req),
    .ready(ready), .rvalid(rvalid), .hit(hit),
    .hit_way(hit_way), .rdirty(rdirty),
    .victim_way(victim_way), .victim_valid(victim_valid),
    .victim_dirty(victim_dirty), .victim_tag(victim_tag),
    .flush_done(flush_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic          hit;
    logic [NW-1:0] hway;
    logic          rd;
    logic [1:0]    vw;
    logic          vv;
    logic          vd;
    logic [TW-1:0] vt;
    int            due;
  } exp_t;

  exp_t sbq[$];

  bit            mv[NS][NW];
  bit            md[NS][NW];
  logic [TW-1:0] mt[NS][NW];
  int            mrr[NS];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic void m_clear();
    for (int s = 0; s < NS; s++) begin
      mrr[s] = 0;
      for (int w = 0; w < NW; w++) begin
        mv[s][w] = 1'b0;
        md[s][w] = 1'b0;
      end
    end
  endfunction

  function automatic exp_t m_op(input logic [1:0] o, input int s,
                                input logic [TW-1:0] t, input int ws,
                                input bit wd);
    exp_t x;
    int w;
    x = '{default: 0};
    w = mrr[s];
    if (o == 2'b01) begin
      x.vw = 2'(w);
      x.vv = mv[s][w];
      x.vd = md[s][w];
      x.vt = mt[s][w];
      mt[s][w] = t;
      mv[s][w] = 1'b1;
      md[s][w] = wd;
      mrr[s] = (w + 1) % NW;
      x.hit = 1'b1;
      x.hway = NW'(1 << w);
      x.rd = wd;
      return x;
    end
    if (o == 2'b10 && mv[s][ws]) md[s][ws] = 1'b1;
    if (o == 2'b11) begin
      mv[s][ws] = 1'b0;
      md[s][ws] = 1'b0;
    end
    for (int i = 0; i < NW; i++)
      if (!x.hit && mv[s][i] && mt[s][i] == t) begin
        x.hit = 1'b1;
        x.hway = NW'(1 << i);
        x.rd = md[s][i];
      end
    x.vw = 2'(w);
    x.vv = mv[s][w];
    x.vd = md[s][w];
    x.vt = mt[s][w];
    return x;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      while (sbq.size() > 0 && sbq[0].due < cyc) begin
        chk("rvalid_missing", 0, 1);
        e = sbq.pop_front();
      end
      if (rvalid) begin
        if (sbq.size() == 0 || sbq[0].due != cyc)
          chk("rvalid_unexpected", 1, 0);
        else begin
          e = sbq.pop_front();
          chk("hit", 32'(hit), 32'(e.hit));
          chk("hit_way", 32'(hit_way), 32'(e.hway));
          chk("rdirty", 32'(rdirty), 32'(e.rd));
          chk("victim_way", 32'(victim_way), 32'(e.vw));
          chk("victim_valid", 32'(victim_valid), 32'(e.vv));
          chk("victim_dirty", 32'(victim_dirty), 32'(e.vd));
          if (e.vv) chk("victim_tag", 32'(victim_tag), 32'(e.vt));
        end
      end
    end
  end

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [1:0] o, input int s,
                       input logic [TW-1:0] t, input int ws,
                       input bit wd);
    exp_t x;
    req = 1'b1;
    op = o;
    addr = 7'(s);
    tag = t;
    way_sel = 2'(ws);
    wdirty = wd;
    x = m_op(o, s, t, ws, wd);
    x.due = cyc + 1;
    sbq.push_back(x);
    idle();
    req = 1'b0;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_ctl"},
        32'({ready, rvalid, hit, hit_way, rdirty, flush_done}), 0);
    chk({nm, "_victim"},
        32'({victim_way, victim_valid, victim_dirty, victim_tag}), 0);
  endtask

  task automatic wait_sweep(input bit exp_done, input int abort_at,
                            output bit aborted);
    int n;
    int dn;
    int bad;
    n = 0;
    dn = 0;
    bad = 0;
    aborted = 1'b0;
    chk("ready_low_at_sweep_start", 32'(ready), 0);
    while (n < 1000) begin
      idle();
      n++;
      if (abort_at > 0 && n == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk_zero("reset_mid_sweep");
        aborted = 1'b1;
        return;
      end
      if (flush_done && ready) dn++;
      if (flush_done && !ready) bad++;
      if (ready) break;
    end
    chk("sweep_cycles", 32'(n), 128);
    chk("flush_done_pulse", 32'(dn), exp_done ? 1 : 0);
    chk("flush_done_early", 32'(bad), 0);
    idle();
    chk("flush_done_width", 32'(flush_done), 0);
  endtask

  task automatic release_reset();
    bit ab;
    idle();
    sbq.delete();
    rst_n = 1'b1;
    m_clear();
    wait_sweep(1'b0, 0, ab);
  endtask

  task automatic flush(input int abort_at);
    bit ab;
    req = 1'b1;
    op = 2'b00;
    addr = 7'd5;
    tag = 20'h12345;
    flush_req = 1'b1;
    idle();
    flush_req = 1'b0;
    req = 1'b0;
    m_clear();
    wait_sweep(1'b1, abort_at, ab);
    if (ab) release_reset();
  endtask

  logic [TW-1:0] tt[5];
  int            pool[4];

  initial begin
    pool[0] = 0;
    pool[1] = 1;
    pool[2] = 2;
    pool[3] = 127;
    #12;
    chk_zero("reset_state");
    release_reset();

    do_op(2'b00, 5, 20'h12345, 0, 0);
    do_op(2'b01, 5, 20'h12345, 0, 0);
    do_op(2'b00, 5, 20'h12345, 0, 0);
    do_op(2'b01, 5, 20'hABCDE, 0, 1);

    for (int i = 0; i < 5; i++) begin
      tt[i] = TW'(32'h10000 + i * 32'h111);
      do_op(2'b01, 7, tt[i], 0, i[0]);
    end
    do_op(2'b00, 7, tt[0], 0, 0);

    do_op(2'b10, 7, tt[2], 2, 0);
    do_op(2'b00, 7, tt[2], 0, 0);
    do_op(2'b11, 7, tt[2], 2, 0);
    do_op(2'b10, 7, tt[2], 2, 0);
    do_op(2'b00, 7, tt[2], 0, 0);

    do_op(2'b01, 9, 20'h00777, 0, 0);
    do_op(2'b01, 9, 20'h00777, 0, 1);
    do_op(2'b00, 9, 20'h00777, 0, 0);
    idle();

    flush(0);
    do_op(2'b00, 5, 20'h12345, 0, 0);
    do_op(2'b00, 7, tt[1], 0, 0);

    do_op(2'b01, 20, 20'h0BEEF, 0, 1);
    idle();
    flush(40);
    do_op(2'b00, 20, 20'h0BEEF, 0, 0);
    do_op(2'b01, 20, 20'h0BEEF, 0, 1);
    do_op(2'b00, 20, 20'h0BEEF, 0, 0);

    for (int i = 0; i < 800; i++) begin
      if (i == 400) begin
        idle();
        flush(0);
      end
      if ($urandom_range(0, 4) == 0) idle();
      else
        do_op(2'($urandom_range(0, 3)),
              pool[$urandom_range(0, 3)],
              TW'(32'h100 + $urandom_range(0, 5)),
              int'($urandom_range(0, NW - 1)),
              1'($urandom_range(0, 1)));
    end

    repeat (3) idle();
    chk("scoreboard_empty", 32'(sbq.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
